bundle_seq: RTL and testbench
=============================

# bundle_seq

Single-issue sequencer between the opcode decoder and the execution datapath (A0/A1 ALUs, multiplier, load/store unit). It accepts one decoded 14-bit control word per bundle over a valid/ready handshake and fires it into the datapath. It holds the bundle until the multi-cycle multiplier and the memory handshake complete, then signals retirement. Decode errors and illegal load/store combinations park the block in a sticky error state until software clears it.

## Interface
- MUL_LAT, 3, multiplier latency in cycles (≥1)
- MEM_TIMEOUT, 64, max cycles mem_req may wait for mem_ack (used only with timeout macro; ≥1)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- bnd_valid  in  1  decoded bundle available
- bnd_ready  out  1  sequencer can accept a bundle
- bnd_ctrl  in  14  decoded control: A0_imm_sel[13] A0_op[12:9] A1_imm_sel[8] A1_op[7:4] M_imm_sel[3] M_en[2] L[1] S[0]
- bnd_err  in  1  decoder error flag for this bundle
- ex_fire  out  1  one-cycle pulse, ex_ctrl valid for datapath
- ex_ctrl  out  14  captured control word, held until next accept
- mul_busy  out  1  multiplier result pending
- mem_req  out  1  memory request, held until acked
- mem_we  out  1  1 = store, 0 = load; valid while mem_req
- mem_ack  in  1  memory completion
- wb_valid  out  1  one-cycle pulse, bundle retired
- err  out  1  sticky error
- err_cause  out  2  00 none, 01 decode, 10 L and S both set, 11 memory timeout
- err_clr  in  1  clears error, returns to IDLE

## Operation
- States: IDLE, EXEC, WAIT, RETIRE, ERR.
- bnd_ready = 1 in IDLE and RETIRE; 0 elsewhere. Accept = bnd_valid & bnd_ready.
- On accept: bnd_err=1 → ERR, cause 01, no ex_fire. L&S both 1 → ERR, cause 10. Else capture bnd_ctrl into ex_ctrl and go to EXEC.
- EXEC: ex_fire=1. mem_req=1 if L|S. Multiplier counter loaded if M_en. Go to RETIRE if every pending op completes this cycle, else go to WAIT.
- Mul completion: the cycle EXEC + MUL_LAT − 1. mul_busy is high from EXEC through that cycle inclusive.
- Mem completion: first cycle with mem_req & mem_ack. mem_req deasserts the next cycle.
- WAIT: hold until all pending ops are complete (completion in the current cycle counts), then go to RETIRE.
- RETIRE: wb_valid=1. Accept a new bundle here if offered, else return to IDLE.
- ERR: bnd_ready=0, err=1, err_cause held. err_clr=1 → IDLE, err=0, cause 00. err_clr outside ERR is ignored.
- Reset (any time, including mid-operation): state IDLE. All outputs 0, ex_ctrl 0, counters 0. An outstanding mem_req drops immediately.

## Timing
- Accept at T → ex_fire at T+1.
- ALU-only bundle: wb_valid at T+2. A back-to-back bundle accepted at T+2 fires at T+3.
- Mul only: wb_valid at T+1+MUL_LAT.
- Mem only, ack first seen at cycle A ≥ T+1: wb_valid at A+1.
- Mul and mem together: wb_valid one cycle after the later completion.
- mem_ack while mem_req=0 is ignored.

## Configuration
- BUNDLE_SEQ_MEM_TIMEOUT_EN defined: a counter runs while mem_req=1. If the count reaches MEM_TIMEOUT without ack, then the next cycle mem_req=0, state goes to ERR, cause 11, and no wb_valid is issued.
- Macro not defined: the block waits for mem_ack indefinitely, cause 11 is never produced, and MEM_TIMEOUT is unused.

## Structure
- Package seq_pkg holds:
  - control bit-index constants (CTL_S=0, CTL_L=1, CTL_M_EN=2, CTL_M_IMM=3, …)
  - state enum
  - err_cause enum
- Sub-module seq_cnt: loadable down-counter with a done flag. One instance counts the multiplier latency. A second instance, present only under the macro, counts the memory timeout.

## Test plan
- ALU-only bundle 14'h2A40 accepted at T → ex_fire T+1 with ex_ctrl=14'h2A40, wb_valid T+2. A second bundle accepted at T+2 → ex_fire T+3.
- Mul bundle (M_en=1), MUL_LAT=3, accepted at T → mul_busy T+1..T+3, wb_valid T+4.
- Load bundle, mem_ack held low for 5 cycles after T+1 → mem_req high T+1..T+6, mem_we=0, wb_valid T+7. Repeat with a store bundle and expect mem_we=1.
- bnd_err=1 → err=1, cause 01, bnd_ready=0, no ex_fire. err_clr → IDLE, and the next bundle is accepted. Bundle with L=S=1 → cause 10.
- With the macro and MEM_TIMEOUT=4, a store that never receives mem_ack → mem_req drops after 4 cycles, cause 11, no wb_valid.
- rst_n low while in WAIT with mem_req high → mem_req=0 immediately. After release: bnd_ready=1 and all other outputs 0.

Source files
------------

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the bundle sequencer:
//   - bit positions inside the 14-bit decoded control word
//   - sequencer state encoding
//   - error cause encoding
// -----------------------------------------------------------------------------
package seq_pkg;

    // Control word layout:
    // A0_imm_sel[13] A0_op[12:9] A1_imm_sel[8] A1_op[7:4] M_imm_sel[3] M_en[2] L[1] S[0]
    localparam int CTL_W      = 14;
    localparam int CTL_S      = 0;
    localparam int CTL_L      = 1;
    localparam int CTL_M_EN   = 2;
    localparam int CTL_M_IMM  = 3;
    localparam int CTL_A1_OPL = 4;
    localparam int CTL_A1_OPH = 7;
    localparam int CTL_A1_IMM = 8;
    localparam int CTL_A0_OPL = 9;
    localparam int CTL_A0_OPH = 12;
    localparam int CTL_A0_IMM = 13;

    // State codes kept as plain constants so they stay usable from older code.
    localparam logic [2:0] ST_IDLE_C   = 3'd0;
    localparam logic [2:0] ST_EXEC_C   = 3'd1;
    localparam logic [2:0] ST_WAIT_C   = 3'd2;
    localparam logic [2:0] ST_RETIRE_C = 3'd3;
    localparam logic [2:0] ST_ERR_C    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_C,
        ST_EXEC   = ST_EXEC_C,
        ST_WAIT   = ST_WAIT_C,
        ST_RETIRE = ST_RETIRE_C,
        ST_ERR    = ST_ERR_C
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_DECODE  = 2'b01,
        CAUSE_LS      = 2'b10,
        CAUSE_TIMEOUT = 2'b11
    } cause_e;

endpackage

// File: rtl/seq_cnt.sv
// -----------------------------------------------------------------------------
// seq_cnt
// Loadable down-counter. Loads i_val, then decrements once per cycle until it
// reaches zero.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : force count to zero (highest priority)
//   i_load     : load i_val
//   i_val      : load value
//   o_busy     : count is non-zero
//   o_done     : count is one, i.e. this is the last counted cycle
// -----------------------------------------------------------------------------
module seq_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_busy,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/bundle_seq.sv
// -----------------------------------------------------------------------------
// bundle_seq
// Single-issue sequencer between the opcode decoder and the execution
// datapath. Accepts one decoded control word per bundle, fires it, waits for
// the multiplier latency and the memory handshake, then retires. Decode
// errors and L+S bundles park the block in a sticky error state.
//
// Optional build macro: BUNDLE_SEQ_MEM_TIMEOUT_EN
//   defined   : mem_req waiting MEM_TIMEOUT cycles without mem_ack aborts
//               the bundle into the error state with cause 11.
//   undefined : mem_ack is awaited indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bnd_valid/ready   bundle handshake from the decoder
//   bnd_ctrl[13:0]    decoded control word
//   bnd_err           decoder error flag for the offered bundle
//   ex_fire           one-cycle pulse, ex_ctrl valid for the datapath
//   ex_ctrl[13:0]     captured control word, held until the next accept
//   mul_busy          multiplier result pending
//   mem_req, mem_we   memory request (held until ack), 1 = store
//   mem_ack           memory completion
//   wb_valid          one-cycle retire pulse
//   err, err_cause    sticky error and its cause
//   err_clr           leaves the error state
// -----------------------------------------------------------------------------
module bundle_seq
    import seq_pkg::*;
#(
    parameter int MUL_LAT     = 3,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bnd_valid,
    output logic        bnd_ready,
    input  logic [13:0] bnd_ctrl,
    input  logic        bnd_err,
    output logic        ex_fire,
    output logic [13:0] ex_ctrl,
    output logic        mul_busy,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        err,
    output logic [1:0]  err_cause,
    input  logic        err_clr
);

    // Counter holds the cycles still to go after EXEC, so MUL_LAT-1 at most.
    localparam int MUL_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);

    state_e      r_state;
    state_e      w_state_nxt;
    cause_e      r_cause;
    cause_e      w_cause_nxt;
    logic [13:0] r_ctrl;
    logic        r_mem_pend;

    logic w_accept;
    logic w_capture;
    logic w_exec;
    logic w_m_en;
    logic w_ls;
    logic w_mul_cnt_busy;
    logic w_mul_cnt_done;
    logic w_mul_busy;
    logic w_mul_done;
    logic w_mem_req;
    logic w_mem_to;
    logic w_all_ok;

    assign w_exec    = (r_state == ST_EXEC);
    assign bnd_ready = (r_state == ST_IDLE) || (r_state == ST_RETIRE);
    assign w_accept  = bnd_valid && bnd_ready;
    assign w_m_en    = r_ctrl[CTL_M_EN];
    assign w_ls      = r_ctrl[CTL_L] | r_ctrl[CTL_S];

    // Multiplier latency. EXEC itself is the first busy cycle; the counter
    // covers the remaining MUL_LAT-1 cycles.
    seq_cnt #(.W(MUL_W)) u_mul_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == ST_ERR),
        .i_load (w_exec && w_m_en),
        .i_val  (MUL_W'(MUL_LAT - 1)),
        .o_busy (w_mul_cnt_busy),
        .o_done (w_mul_cnt_done)
    );

    assign w_mul_busy = w_exec ? w_m_en : w_mul_cnt_busy;
    assign w_mul_done = w_exec ? (w_m_en && (MUL_LAT == 1)) : w_mul_cnt_done;

    // mem_req is raised combinationally in EXEC, then held by r_mem_pend.
    assign w_mem_req = (w_exec && w_ls) || r_mem_pend;

`ifdef BUNDLE_SEQ_MEM_TIMEOUT_EN
    localparam int TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    logic w_to_busy;
    logic w_to_done;

    // Cleared whenever no request is outstanding so a stale count can never
    // leak into the next bundle.
    seq_cnt #(.W(TO_W)) u_to_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (!w_mem_req),
        .i_load (w_exec && w_ls),
        .i_val  (TO_W'(MEM_TIMEOUT - 1)),
        .o_busy (w_to_busy),
        .o_done (w_to_done)
    );

    // Outside EXEC an empty counter also means the budget is spent.
    assign w_mem_to = w_mem_req && !mem_ack &&
                      (w_exec ? (MEM_TIMEOUT == 1) : (w_to_done || !w_to_busy));
`else
    // No timeout in this build; the parameter only takes part in a dead term.
    assign w_mem_to = 1'b0 & (MEM_TIMEOUT > 0);
`endif

    assign w_all_ok = (!w_mul_busy || w_mul_done) && (!w_mem_req || mem_ack);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE, ST_RETIRE: begin
                w_state_nxt = ST_IDLE;
                if (w_accept) begin
                    if (bnd_err) begin
                        w_state_nxt = ST_ERR;
                        w_cause_nxt = CAUSE_DECODE;
                    end else if (bnd_ctrl[CTL_L] && bnd_ctrl[CTL_S]) begin
                        w_state_nxt = ST_ERR;
                        w_cause_nxt = CAUSE_LS;
                    end else begin
                        w_state_nxt = ST_EXEC;
                        w_capture   = 1'b1;
                    end
                end
            end
            ST_EXEC, ST_WAIT: begin
                if (w_mem_to) begin
                    w_state_nxt = ST_ERR;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end else if (w_all_ok) begin
                    w_state_nxt = ST_RETIRE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    w_state_nxt = ST_IDLE;
                    w_cause_nxt = CAUSE_NONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cause_nxt = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cause    <= CAUSE_NONE;
            r_ctrl     <= '0;
            r_mem_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cause    <= w_cause_nxt;
            r_mem_pend <= w_mem_req && !mem_ack && !w_mem_to;
            if (w_capture) begin
                r_ctrl <= bnd_ctrl;
            end
        end
    end

    assign ex_fire   = w_exec;
    assign ex_ctrl   = r_ctrl;
    assign mul_busy  = w_mul_busy;
    assign mem_req   = w_mem_req;
    assign mem_we    = w_mem_req && r_ctrl[CTL_S];
    assign wb_valid  = (r_state == ST_RETIRE);
    assign err       = (r_state == ST_ERR);
    assign err_cause = r_cause;

endmodule

// File: tb/tb_bundle_seq.sv
// -----------------------------------------------------------------------------
// tb_bundle_seq
// Scoreboard bench for bundle_seq (MUL_LAT=3, MEM_TIMEOUT=4). Each accepted
// bundle pushes its expected fire cycle/control word and retire cycle; a
// negedge monitor pops and compares when ex_fire / wb_valid appear.
// -----------------------------------------------------------------------------
module tb_bundle_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bnd_valid = 1'b0;
    logic        bnd_err = 1'b0;
    logic        mem_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic [13:0] bnd_ctrl = '0;

    logic        bnd_ready;
    logic        ex_fire;
    logic [13:0] ex_ctrl;
    logic        mul_busy;
    logic        mem_req;
    logic        mem_we;
    logic        wb_valid;
    logic        err;
    logic [1:0]  err_cause;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          cyc;
        logic [13:0] ctrl;
    } fire_t;

    fire_t fire_q[$];
    int    rtr_q[$];

    bundle_seq #(.MUL_LAT(3), .MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bnd_valid (bnd_valid),
        .bnd_ready (bnd_ready),
        .bnd_ctrl  (bnd_ctrl),
        .bnd_err   (bnd_err),
        .ex_fire   (ex_fire),
        .ex_ctrl   (ex_ctrl),
        .mul_busy  (mul_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .wb_valid  (wb_valid),
        .err       (err),
        .err_cause (err_cause),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a bundle until accepted; t returns the accept cycle.
    task automatic send(input logic [13:0] c, input logic e, output int t);
        int n;
        bnd_ctrl  = c;
        bnd_err   = e;
        bnd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bnd_ready && n < 50);
        if (!bnd_ready) chk("send_ready", bnd_ready, 1);
        t = cyc;
        @(posedge clk);
        #1;
        bnd_valid = 1'b0;
        bnd_err   = 1'b0;
    endtask

    task automatic expect_bundle(input logic [13:0] c, input int t, input int lat);
        fire_q.push_back('{cyc: t + 1, ctrl: c});
        rtr_q.push_back(t + lat);
    endtask

    always @(negedge clk) begin : mon
        fire_t f;
        int    r;
        if (rst_n) begin
            if (ex_fire) begin
                if (fire_q.size() == 0) begin
                    chk("fire_unexpected", fire_q.size(), 1);
                end else begin
                    f = fire_q.pop_front();
                    chk("fire_cycle", cyc, f.cyc);
                    chk("fire_ctrl", ex_ctrl, f.ctrl);
                end
            end
            if (wb_valid) begin
                if (rtr_q.size() == 0) begin
                    chk("wb_unexpected", rtr_q.size(), 1);
                end else begin
                    r = rtr_q.pop_front();
                    chk("wb_cycle", cyc, r);
                end
            end
        end
    end

    task automatic mem_test(input logic [13:0] c, input logic we);
        int t;
        send(c, 1'b0, t);
        expect_bundle(c, t, 7);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) mem_ack = 1'b1;
            @(negedge clk);
            chk("mem_req_hold", mem_req, 1);
            chk("mem_we", mem_we, we);
            step();
            mem_ack = 1'b0;
        end
        @(negedge clk);
        chk("mem_req_release", mem_req, 0);
        step();
        step();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        chk("clr_err", err, 0);
        chk("clr_cause", err_cause, 0);
        chk("clr_ready", bnd_ready, 1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

    initial begin
        int t;
        int t2;

        // Reset state
        @(negedge clk);
        chk("rst_ready", bnd_ready, 1);
        chk("rst_fire", ex_fire, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_mul", mul_busy, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_wb", wb_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_cause", err_cause, 0);
        step();
        rst_n = 1'b1;
        step();

        // ALU-only, then back-to-back accept in RETIRE
        send(14'h2A40, 1'b0, t);
        expect_bundle(14'h2A40, t, 2);
        send(14'h1230, 1'b0, t2);
        chk("b2b_accept", t2, t + 2);
        expect_bundle(14'h1230, t2, 2);
        repeat (3) step();

        // Multiplier only
        send(14'h0004, 1'b0, t);
        expect_bundle(14'h0004, t, 4);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("mul_busy_on", mul_busy, 1);
            step();
        end
        @(negedge clk);
        chk("mul_busy_off", mul_busy, 0);
        step();
        step();

        // Load then store, ack after 5 low cycles
        mem_test(14'h0002, 1'b0);
        mem_test(14'h0001, 1'b1);

        // Multiplier plus load acked immediately: mul completes later
        send(14'h0006, 1'b0, t);
        expect_bundle(14'h0006, t, 4);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("mm_req", mem_req, 1);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("mm_req_drop", mem_req, 0);
        chk("mm_mul", mul_busy, 1);
        repeat (3) step();

        // Stray ack with no request does nothing
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_req", mem_req, 0);
        chk("stray_ack_ready", bnd_ready, 1);
        step();

        // Decode error
        send(14'h2A40, 1'b1, t);
        @(negedge clk);
        chk("dec_err", err, 1);
        chk("dec_cause", err_cause, 1);
        chk("dec_ready", bnd_ready, 0);
        chk("dec_fire", ex_fire, 0);
        clear_err();
        send(14'h0010, 1'b0, t);
        expect_bundle(14'h0010, t, 2);
        step();
        step();

        // L and S together
        send(14'h0003, 1'b0, t);
        @(negedge clk);
        chk("ls_err", err, 1);
        chk("ls_cause", err_cause, 2);
        chk("ls_fire", ex_fire, 0);
        clear_err();

`ifdef BUNDLE_SEQ_MEM_TIMEOUT_EN
        // Store that is never acknowledged
        send(14'h0001, 1'b0, t);
        fire_q.push_back('{cyc: t + 1, ctrl: 14'h0001});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("to_req_hold", mem_req, 1);
            step();
        end
        @(negedge clk);
        chk("to_req_drop", mem_req, 0);
        chk("to_err", err, 1);
        chk("to_cause", err_cause, 3);
        clear_err();
`endif

        // Reset while waiting on memory
        send(14'h0002, 1'b0, t);
        fire_q.push_back('{cyc: t + 1, ctrl: 14'h0002});
        step();
        @(negedge clk);
        chk("wait_req", mem_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_ready", bnd_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_ready", bnd_ready, 1);
        chk("post_fire", ex_fire, 0);
        chk("post_ctrl", ex_ctrl, 0);
        chk("post_mul", mul_busy, 0);
        chk("post_req", mem_req, 0);
        chk("post_we", mem_we, 0);
        chk("post_wb", wb_valid, 0);
        chk("post_err", err, 0);
        chk("post_cause", err_cause, 0);
        step();

        chk("fire_q_empty", fire_q.size(), 0);
        chk("rtr_q_empty", rtr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
